tdm_demux4: RTL and testbench
=============================

// Module: tdm_demux4
// PURPOSE
//  Receive-side counterpart of the 4-to-1 channel mux: takes a time-division
//  multiplexed stream, one channel per beat in slot order 0,1,2,3, and rebuilds
//  four parallel registered outputs y0..y3.
//  Frame alignment comes from a start-of-frame flag on slot 0. y0..y3 update
//  atomically once per complete frame, with a one-cycle out_valid strobe.
// PARAMETERS
//  DATA_W  8  width of each channel sample and of in_data
// PORTS
//  clk        in   1       single clock; all logic on rising edge
//  rst        in   1       synchronous reset, active-high
//  in_valid   in   1       beat present on in_data this cycle
//  in_data    in   DATA_W  sample for the current slot
//  in_sof     in   1       qualifies beat as slot 0 (valid only with in_valid)
//  y0..y3     out  DATA_W  channel 0..3 sample of last complete frame
//  out_valid  out  1       1-cycle pulse: y0..y3 just updated
//  slot       out  2       slot index expected for next accepted beat
//  locked     out  1       1 in RUN state
//  sync_err   out  1       1-cycle pulse on framing violation
// BEHAVIOUR
//  Reset (rst=1 at edge): state=HUNT; slot=0; y0..y3=0; out_valid=0;
//   sync_err=0; shadow regs=0. Reset mid-frame discards the partial frame.
//  Beats are accepted only when in_valid=1. in_valid=0: no state, slot or
//   shadow change; out_valid and sync_err are 0 that cycle.
//  HUNT: beats with in_sof=0 are dropped silently (no sync_err).
//   Beat with in_sof=1: shadow0<=in_data; slot<=1; state<=RUN.
//  RUN, accepted beat:
//   - in_sof=1 and slot!=0: sync_err pulse; partial frame dropped;
//     beat is taken as the new slot 0 (shadow0<=in_data; slot<=1); stay RUN.
//   - in_sof=0 and slot==0: sync_err pulse; beat dropped; slot<=0;
//     state<=HUNT.
//   - otherwise, slot 0..2: shadow[slot]<=in_data; slot<=slot+1.
//   - otherwise, slot 3: y0<=shadow0, y1<=shadow1, y2<=shadow2, y3<=in_data,
//     all at the same edge; out_valid=1 for the following cycle; slot wraps to 0.
//  Latency: y0..y3 and out_valid are visible the cycle after the slot-3 beat.
//   Back-to-back frames are allowed: one beat per cycle gives out_valid
//   every 4th cycle.
//  y0..y3 hold their value between frames, in HUNT, and across sync errors.
//   They change only on a completed frame or on reset.
//  out_valid and sync_err are never asserted in the same cycle.
//  locked=1 exactly when state==RUN (registered, from state).
//  slot is a modulo-4 counter with no overflow beyond wrap 3->0.
// TESTING
//  T1 reset: rst=1 for 2 cycles, then idle -> y0..y3=0, out_valid=0,
//     slot=0, locked=0.
//  T2 one frame: beats {sof:11},22,33,44 on consecutive cycles ->
//     next cycle y0=11, y1=22, y2=33, y3=44, out_valid=1 for exactly 1 cycle.
//  T3 gaps: same frame with in_valid=0 for 3 cycles between each beat ->
//     identical outputs, one out_valid pulse, slot holds during gaps.
//  T4 early sof: {sof:01},02,{sof:A0},A1,A2,A3 -> sync_err pulse on 3rd beat,
//     then y=A0,A1,A2,A3; 01/02 never appear on any output.
//  T5 lost sof: after a good frame, send 55 (sof=0) at slot 0 ->
//     sync_err pulse, locked=0, y unchanged. Then {sof:66},77,88,99 ->
//     relock, y=66,77,88,99.
//  T6 mid-frame reset: {sof:C0},C1 then rst=1 ->
//     y=0, slot=0, HUNT; no out_valid.

Source files
------------

// File: rtl/tdm_demux4.sv
// TDM receive demux: rebuilds four parallel channel samples from a
// slot-ordered beat stream aligned by a start-of-frame flag on slot 0.
module tdm_demux4 #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    output logic [DATA_W-1:0] y0,
    output logic [DATA_W-1:0] y1,
    output logic [DATA_W-1:0] y2,
    output logic [DATA_W-1:0] y3,
    output logic              out_valid,
    output logic [1:0]        slot,
    output logic              locked,
    output logic              sync_err
);

    typedef enum logic {HUNT, RUN} state_t;

    state_t            state_q, state_d;
    logic [1:0]        slot_q, slot_d;
    logic [DATA_W-1:0] sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
    logic [DATA_W-1:0] y0_q, y0_d, y1_q, y1_d, y2_q, y2_d, y3_q, y3_d;
    logic              ov_q, ov_d, err_q, err_d;

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        sh0_d   = sh0_q;
        sh1_d   = sh1_q;
        sh2_d   = sh2_q;
        y0_d    = y0_q;
        y1_d    = y1_q;
        y2_d    = y2_q;
        y3_d    = y3_q;
        ov_d    = 1'b0;
        err_d   = 1'b0;
        if (in_valid) begin
            if (state_q == HUNT) begin
                if (in_sof) begin
                    sh0_d   = in_data;
                    slot_d  = 2'd1;
                    state_d = RUN;
                end
            end else if (in_sof && slot_q != 2'd0) begin
                // Early SOF restarts the frame on this beat
                err_d  = 1'b1;
                sh0_d  = in_data;
                slot_d = 2'd1;
            end else if (!in_sof && slot_q == 2'd0) begin
                err_d   = 1'b1;
                slot_d  = 2'd0;
                state_d = HUNT;
            end else begin
                unique case (slot_q)
                    2'd0: sh0_d = in_data;
                    2'd1: sh1_d = in_data;
                    2'd2: sh2_d = in_data;
                    2'd3: begin
                        y0_d = sh0_q;
                        y1_d = sh1_q;
                        y2_d = sh2_q;
                        y3_d = in_data;
                        ov_d = 1'b1;
                    end
                endcase
                slot_d = slot_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            slot_q  <= '0;
            sh0_q   <= '0;
            sh1_q   <= '0;
            sh2_q   <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            y2_q    <= '0;
            y3_q    <= '0;
            ov_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
            sh2_q   <= sh2_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            y2_q    <= y2_d;
            y3_q    <= y3_d;
            ov_q    <= ov_d;
            err_q   <= err_d;
        end
    end

    assign y0        = y0_q;
    assign y1        = y1_q;
    assign y2        = y2_q;
    assign y3        = y3_q;
    assign out_valid = ov_q;
    assign sync_err  = err_q;
    assign slot      = slot_q;
    assign locked    = (state_q == RUN);

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: directed frames plus randomized beats checked
// against a frame-level reference model.
module tb_tdm_demux4;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_sof;
    logic [DW-1:0] y0, y1, y2, y3;
    logic          out_valid;
    logic [1:0]    slot;
    logic          locked;
    logic          sync_err;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model
    bit       m_run;
    int       m_slot;
    int       m_sh[4];
    int       m_y[4];
    bit       m_ov, m_err;
    int       ov_seen;

    tdm_demux4 #(.DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_sof(in_sof), .y0(y0), .y1(y1), .y2(y2), .y3(y3),
        .out_valid(out_valid), .slot(slot), .locked(locked),
        .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model(input bit r, input bit v, input bit s,
                         input int d);
        m_ov  = 0;
        m_err = 0;
        if (r) begin
            m_run  = 0;
            m_slot = 0;
            foreach (m_sh[i]) m_sh[i] = 0;
            foreach (m_y[i]) m_y[i] = 0;
        end else if (v) begin
            if (!m_run) begin
                if (s) begin
                    m_sh[0] = d;
                    m_slot  = 1;
                    m_run   = 1;
                end
            end else if (s && m_slot != 0) begin
                m_err   = 1;
                m_sh[0] = d;
                m_slot  = 1;
            end else if (!s && m_slot == 0) begin
                m_err = 1;
                m_run = 0;
            end else if (m_slot < 3) begin
                m_sh[m_slot] = d;
                m_slot++;
            end else begin
                m_y[0] = m_sh[0];
                m_y[1] = m_sh[1];
                m_y[2] = m_sh[2];
                m_y[3] = d;
                m_ov   = 1;
                m_slot = 0;
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input bit s,
                        input int d);
        rst      = r;
        in_valid = v;
        in_sof   = s;
        in_data  = d[DW-1:0];
        @(posedge clk);
        model(r, v, s, d);
        #1;
        if (out_valid) ov_seen++;
        chk("y0", y0, m_y[0]);
        chk("y1", y1, m_y[1]);
        chk("y2", y2, m_y[2]);
        chk("y3", y3, m_y[3]);
        chk("out_valid", out_valid, m_ov);
        chk("sync_err", sync_err, m_err);
        chk("slot", slot, m_slot);
        chk("locked", locked, m_run);
        chk("ov_err_excl", out_valid & sync_err, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, $urandom_range(255));
    endtask

    initial begin
        int pos;
        bit v, s, r;
        rst = 1; in_valid = 0; in_sof = 0; in_data = '0;

        // T1 reset
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        idle(2);
        chk("t1_y0", y0, 0);
        chk("t1_locked", locked, 0);

        // T2 one frame
        ov_seen = 0;
        step(0, 1, 1, 'h11);
        step(0, 1, 0, 'h22);
        step(0, 1, 0, 'h33);
        step(0, 1, 0, 'h44);
        chk("t2_y", {y0, y1, y2, y3}, 32'h11223344);
        chk("t2_ov", out_valid, 1);
        idle(2);
        chk("t2_pulses", ov_seen, 1);

        // T3 gaps
        ov_seen = 0;
        step(0, 1, 1, 'h15);
        idle(3);
        step(0, 1, 0, 'h26);
        idle(3);
        chk("t3_slot_gap", slot, 2);
        step(0, 1, 0, 'h37);
        idle(3);
        step(0, 1, 0, 'h48);
        chk("t3_y", {y0, y1, y2, y3}, 32'h15263748);
        idle(3);
        chk("t3_pulses", ov_seen, 1);

        // T4 early sof
        step(0, 1, 1, 'h01);
        step(0, 1, 0, 'h02);
        step(0, 1, 1, 'hA0);
        chk("t4_err", sync_err, 1);
        step(0, 1, 0, 'hA1);
        step(0, 1, 0, 'hA2);
        step(0, 1, 0, 'hA3);
        chk("t4_y", {y0, y1, y2, y3}, 32'hA0A1A2A3);

        // T5 lost sof
        step(0, 1, 0, 'h55);
        chk("t5_err", sync_err, 1);
        chk("t5_locked", locked, 0);
        chk("t5_y_hold", {y0, y1, y2, y3}, 32'hA0A1A2A3);
        step(0, 1, 1, 'h66);
        chk("t5_relock", locked, 1);
        step(0, 1, 0, 'h77);
        step(0, 1, 0, 'h88);
        step(0, 1, 0, 'h99);
        chk("t5_y", {y0, y1, y2, y3}, 32'h66778899);

        // T6 mid-frame reset
        ov_seen = 0;
        step(0, 1, 1, 'hC0);
        step(0, 1, 0, 'hC1);
        step(1, 0, 0, 0);
        chk("t6_y", {y0, y1, y2, y3}, 0);
        chk("t6_slot", slot, 0);
        chk("t6_locked", locked, 0);
        step(0, 1, 0, 'hC2);
        step(0, 1, 0, 'hC3);
        chk("t6_no_ov", ov_seen, 0);

        // randomized, mostly well-formed stream with injected faults
        pos = 0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(299) == 0);
            v = ($urandom_range(3) != 0);
            s = (pos == 0);
            if ($urandom_range(15) == 0) s = !s;
            step(r, v, s, $urandom_range(255));
            if (r) pos = 0;
            else if (v) pos = s ? 1 : (pos + 1) % 4;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
